// File: rtl/phy_tx_link_sched.sv
// Link-state controller plus 2-requester round-robin scheduler feeding phy_TX.
// The TX path stays idle until the lane reports active, and it falls back to idle when active is lost.
module phy_tx_link_sched #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    INIT_CYCLES = 4,
  parameter int                    ACTIVE_HOLD = 2,
  parameter int                    MAX_BURST   = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = 32'hBCBCBCBC
) (
  input  logic                  clk_f,
  input  logic                  reset,
  input  logic                  active,
  input  logic                  valid_0,
  input  logic [DATA_WIDTH-1:0] data_0,
  output logic                  ready_0,
  input  logic                  valid_1,
  input  logic [DATA_WIDTH-1:0] data_1,
  output logic                  ready_1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  grant_id,
  output logic [1:0]            state
);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int HW = $clog2(ACTIVE_HOLD + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {S_INIT = 2'd0, S_WAIT = 2'd1, S_ACTIVE = 2'd2} state_t;

  state_t                st;
  logic [IW-1:0]         init_cnt;
  logic [HW-1:0]         hold_cnt;
  logic [BW-1:0]         burst_cnt;
  logic                  owner;
  logic                  sel;
  logic                  live;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] data_sel;

  assign state = st;

  // The burst limit only matters under contention; a lone requester always wins.
  always_comb begin
    sel = owner;
    if (valid_0 && !valid_1)                 sel = 1'b0;
    else if (valid_1 && !valid_0)            sel = 1'b1;
    else if (burst_cnt >= BW'(MAX_BURST))    sel = ~owner;
  end

  // Reset gates ready so that no word is acknowledged on an edge that discards it.
  assign live     = (st == S_ACTIVE) && active && !reset;
  assign ready_0  = live && valid_0 && !sel;
  assign ready_1  = live && valid_1 && sel;
  assign xfer     = ready_0 || ready_1;
  assign data_sel = sel ? data_1 : data_0;

  always_ff @(posedge clk_f) begin
    if (reset) begin
      st        <= S_INIT;
      data_out  <= '0;
      valid_out <= 1'b0;
      grant_id  <= 1'b0;
      init_cnt  <= '0;
      hold_cnt  <= '0;
      owner     <= 1'b0;
      burst_cnt <= '0;
    end else begin
      case (st)
        S_INIT: begin
          data_out  <= '0;
          valid_out <= 1'b0;
          if (init_cnt == IW'(INIT_CYCLES - 1)) begin
            st       <= S_WAIT;
            init_cnt <= '0;
            hold_cnt <= '0;
            data_out <= IDLE_WORD;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          data_out  <= IDLE_WORD;
          valid_out <= 1'b0;
          if (!active) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HW'(ACTIVE_HOLD - 1)) begin
            st       <= S_ACTIVE;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_ACTIVE: begin
          if (!active) begin
            st        <= S_WAIT;
            hold_cnt  <= '0;
            burst_cnt <= '0;
            data_out  <= IDLE_WORD;
            valid_out <= 1'b0;
          end else if (xfer) begin
            data_out  <= data_sel;
            valid_out <= 1'b1;
            grant_id  <= sel;
            if (sel == owner) begin
              if (burst_cnt != BW'(MAX_BURST)) burst_cnt <= burst_cnt + 1'b1;
            end else begin
              owner     <= sel;
              burst_cnt <= BW'(1);
            end
          end else begin
            data_out  <= IDLE_WORD;
            valid_out <= 1'b0;
          end
        end
        default: begin
          st        <= S_INIT;
          init_cnt  <= '0;
          data_out  <= '0;
          valid_out <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_phy_tx_link_sched.sv
// Scoreboard bench for phy_tx_link_sched: the stimulus pushes hand-computed output words and a negedge monitor pops them.
module tb_phy_tx_link_sched;
  localparam logic [31:0] IDLE = 32'hBCBCBCBC;

  logic        clk_f = 1'b0;
  logic        reset = 1'b1;
  logic        active = 1'b0;
  logic        valid_0 = 1'b0, valid_1 = 1'b0;
  logic [31:0] data_0 = '0, data_1 = '0;
  logic        ready_0, ready_1, valid_out, grant_id;
  logic [31:0] data_out;
  logic [1:0]  state;

  phy_tx_link_sched dut (
    .clk_f(clk_f), .reset(reset), .active(active),
    .valid_0(valid_0), .data_0(data_0), .ready_0(ready_0),
    .valid_1(valid_1), .data_1(data_1), .ready_1(ready_1),
    .data_out(data_out), .valid_out(valid_out), .grant_id(grant_id), .state(state)
  );

  always #5 clk_f = ~clk_f;

  int          errors = 0;
  int          checks = 0;
  logic [32:0] exp_q[$];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        r0, r1;
  logic [32:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Each presented word must match the head of the expected queue.
  always @(negedge clk_f) begin
    if (valid_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got grant=%0d data=%h expected none", grant_id, data_out);
      end else begin
        mon_e = exp_q.pop_front();
        if ({grant_id, data_out} !== mon_e) begin
          errors++;
          $display("FAIL out_word: got grant=%0d data=%h expected grant=%0d data=%h",
                   grant_id, data_out, mon_e[32], mon_e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_f);
    #1;
  endtask

  // Requesters present the queue heads and pop them once ready has been seen at the edge.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      valid_0 = (q0.size() > 0);
      data_0  = valid_0 ? q0[0] : '0;
      valid_1 = (q1.size() > 0);
      data_1  = valid_1 ? q1[0] : '0;
      @(negedge clk_f);
      r0 = ready_0;
      r1 = ready_1;
      checks++;
      if (r0 && r1) begin
        errors++;
        $display("FAIL ready_exclusive: got ready_0=1 ready_1=1 expected at most one");
      end
      @(posedge clk_f);
      #1;
      if (r0) void'(q0.pop_front());
      if (r1) void'(q1.pop_front());
    end
  endtask

  task automatic push_word(input logic g, input logic [31:0] w);
    exp_q.push_back({g, w});
  endtask

  task automatic init_sequence(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_init_state"}, 32'(state), 32'd0);
      chk({tag, "_init_data"}, data_out, 32'd0);
      chk({tag, "_init_valid"}, 32'(valid_out), 32'd0);
      tick();
    end
    chk({tag, "_wait_state"}, 32'(state), 32'd1);
    chk({tag, "_wait_data"}, data_out, IDLE);
    chk({tag, "_wait_valid"}, 32'(valid_out), 32'd0);
  endtask

  initial begin
    // 1: reset then INIT/WAIT with active low
    reset = 1'b1;
    tick();
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    reset = 1'b0;
    init_sequence("t1");
    tick();
    tick();
    chk("t1_wait_hold", 32'(state), 32'd1);

    // 2: active pulses 1,0,1,1
    active = 1'b1; tick(); chk("t2_a1", 32'(state), 32'd1);
    active = 1'b0; tick(); chk("t2_a0", 32'(state), 32'd1);
    active = 1'b1; tick(); chk("t2_a1b", 32'(state), 32'd1);
    tick();
    chk("t2_active", 32'(state), 32'd2);
    chk("t2_idle_data", data_out, IDLE);
    chk("t2_idle_valid", 32'(valid_out), 32'd0);

    // 3: lone requester 0, six words, owner 0 burst saturates at 4
    for (int i = 1; i <= 6; i++) begin
      q0.push_back(32'h11111111 * i);
      push_word(1'b0, 32'h11111111 * i);
    end
    run_cycles(7);
    chk("t3_drain", 32'(exp_q.size()), 32'd0);

    // 4: both valid, entering with owner 0 at burst 4 so requester 1 goes first
    for (int i = 0; i < 6; i++) begin
      q0.push_back(32'hA0000000 + i);
      q1.push_back(32'hB0000000 + i);
    end
    for (int i = 0; i < 4; i++) push_word(1'b1, 32'hB0000000 + i);
    for (int i = 0; i < 4; i++) push_word(1'b0, 32'hA0000000 + i);
    push_word(1'b1, 32'hB0000004);
    push_word(1'b1, 32'hB0000005);
    push_word(1'b0, 32'hA0000004);
    push_word(1'b0, 32'hA0000005);
    run_cycles(13);
    chk("t4_drain", 32'(exp_q.size()), 32'd0);

    // 5: drop active mid-burst (owner 0 at burst 2 on entry)
    for (int i = 0; i < 4; i++) begin
      q0.push_back(32'hC0000000 + i);
      q1.push_back(32'hD0000000 + i);
    end
    push_word(1'b0, 32'hC0000000);
    push_word(1'b0, 32'hC0000001);
    push_word(1'b1, 32'hD0000000);
    push_word(1'b1, 32'hD0000001);
    run_cycles(4);
    active = 1'b0;
    run_cycles(1);
    chk("t5_drop_ready", {30'd0, r0, r1}, 32'd0);
    chk("t5_drop_state", 32'(state), 32'd1);
    chk("t5_drop_valid", 32'(valid_out), 32'd0);
    chk("t5_drop_data", data_out, IDLE);
    run_cycles(1);
    active = 1'b1;
    run_cycles(2);
    chk("t5_reenter", 32'(state), 32'd2);
    push_word(1'b1, 32'hD0000002);
    push_word(1'b1, 32'hD0000003);
    push_word(1'b0, 32'hC0000002);
    push_word(1'b0, 32'hC0000003);
    run_cycles(5);
    chk("t5_drain", 32'(exp_q.size()), 32'd0);

    // 6: reset during ACTIVE transfers, then full bring-up again
    for (int i = 0; i < 4; i++) q0.push_back(32'hE0000000 + i);
    push_word(1'b0, 32'hE0000000);
    push_word(1'b0, 32'hE0000001);
    run_cycles(2);
    reset  = 1'b1;
    active = 1'b0;
    run_cycles(1);
    chk("t6_rst_cycle_ready", {30'd0, r0, r1}, 32'd0);
    chk("t6_state", 32'(state), 32'd0);
    chk("t6_data", data_out, 32'd0);
    chk("t6_valid", 32'(valid_out), 32'd0);
    chk("t6_ready", {30'd0, ready_0, ready_1}, 32'd0);
    reset = 1'b0;
    q0.delete();
    valid_0 = 1'b0;
    init_sequence("t6");
    active = 1'b1;
    tick();
    tick();
    chk("t6_active", 32'(state), 32'd2);

    // fresh arbitration from reset: 0,0,0,0,1,1,1,1,0,1
    for (int i = 0; i < 5; i++) begin
      q0.push_back(32'hF0000000 + i);
      q1.push_back(32'h60000000 + i);
    end
    for (int i = 0; i < 4; i++) push_word(1'b0, 32'hF0000000 + i);
    for (int i = 0; i < 4; i++) push_word(1'b1, 32'h60000000 + i);
    push_word(1'b0, 32'hF0000004);
    push_word(1'b1, 32'h60000004);
    run_cycles(11);
    tick();
    tick();
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
